// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - FIFO of ALU requests feeding an external combinational ALU, with a registered result stage
// Holds DEPTH queued requests plus one result; flag_z tracks the zero flag of the last consumed result.
module alu_issue_queue #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_op,
   input  logic [W-1:0]             in_a,
   input  logic [W-1:0]             in_b,
   output logic [W-1:0]             alu_a,
   output logic [W-1:0]             alu_b,
   output logic [1:0]               alu_op,
   input  logic [W-1:0]             alu_out,
   input  logic                     alu_z,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [W-1:0]             res_data,
   output logic                     res_z,
   output logic                     flag_z,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_op
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [1:0]    fifo_op_q [DEPTH];
   logic [W-1:0]  fifo_a_q  [DEPTH];
   logic [W-1:0]  fifo_b_q  [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          res_valid_q, res_valid_d;
   logic [W-1:0]  res_data_q, res_data_d;
   logic          res_z_q, res_z_d;
   logic          flag_z_q, flag_z_d;
   logic          err_op_q, err_op_d;

   logic          push, illegal, pop, not_empty;

   assign not_empty = (count_q != '0);
   assign in_ready  = (count_q < CW'(DEPTH));
   assign push      = in_valid && in_ready && (in_op != 2'd3);
   assign illegal   = in_valid && in_ready && (in_op == 2'd3);
   // A pop moves the head into the result register, so it needs that register free or draining.
   assign pop       = not_empty && (!res_valid_q || res_ready);

   assign alu_a  = not_empty ? fifo_a_q[rd_ptr_q]  : '0;
   assign alu_b  = not_empty ? fifo_b_q[rd_ptr_q]  : '0;
   assign alu_op = not_empty ? fifo_op_q[rd_ptr_q] : 2'd2;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_z_d     = res_z_q;
      flag_z_d    = flag_z_q;
      err_op_d    = illegal;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (pop) begin
         res_valid_d = 1'b1;
         res_data_d  = alu_out;
         res_z_d     = alu_z;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      if (res_valid_q && res_ready) flag_z_d = res_z_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_z_q     <= 1'b0;
         flag_z_q    <= 1'b0;
         err_op_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_z_q     <= res_z_d;
         flag_z_q    <= flag_z_d;
         err_op_q    <= err_op_d;
      end
   end

   // Storage needs no reset: entries are only visible while count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op_q[wr_ptr_q] <= in_op;
         fifo_a_q[wr_ptr_q]  <= in_a;
         fifo_b_q[wr_ptr_q]  <= in_b;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_z     = res_z_q;
   assign flag_z    = flag_z_q;
   assign count     = count_q;
   assign err_op    = err_op_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - scoreboard bench for alu_issue_queue
// Inputs change 1ns after the rising edge; handshakes and outputs are sampled on the falling edge.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;
   localparam int W     = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    in_op;
   logic [W-1:0]  in_a, in_b;
   logic [W-1:0]  alu_a, alu_b;
   logic [1:0]    alu_op;
   logic [W-1:0]  alu_out;
   logic          alu_z;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic          res_z;
   logic          flag_z;
   logic [2:0]    count;
   logic          err_op;

   int n_cmp = 0;
   int n_err = 0;
   logic [W:0] exp_q[$];

   always #5 clk = ~clk;

   alu_issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_z(alu_z),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_z(res_z),
      .flag_z(flag_z), .count(count), .err_op(err_op)
   );

   // External combinational ALU
   always_comb begin
      case (alu_op)
         2'd0:    alu_out = alu_a + alu_b;
         2'd1:    alu_out = alu_a ^ alu_b;
         2'd2:    alu_out = alu_b;
         default: alu_out = '0;
      endcase
      alu_z = (alu_out == '0);
   end

   function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         2'd0:    r = a + b;
         2'd1:    r = a ^ b;
         default: r = b;
      endcase
      return {(r == '0), r};
   endfunction

   task automatic tick();
      logic [W:0] e;
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got data=%h z=%b, required no result", res_data, res_z);
         end else begin
            e = exp_q.pop_front();
            if ({res_z, res_data} !== e) begin
               n_err++;
               $display("FAIL sb_result: got z=%b data=%h, required z=%b data=%h", res_z, res_data, e[W], e[W-1:0]);
            end
         end
      end
      if (rst_n && in_valid && in_ready && in_op != 2'd3) exp_q.push_back(model(in_op, in_a, in_b));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int guard = 0;
      in_valid  = 1'b0;
      res_ready = 1'b1;
      while ((exp_q.size() != 0 || res_valid) && guard < 40) begin
         tick();
         guard++;
      end
      n_cmp++;
      if (guard >= 40) begin
         n_err++;
         $display("FAIL drain_timeout: pending=%0d res_valid=%b, required 0/0", exp_q.size(), res_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
      n_cmp++; if (res_valid !== 1'b0)  begin n_err++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
      n_cmp++; if (count !== 3'd0)      begin n_err++; $display("FAIL rst_count: got %0d, required 0", count); end
      n_cmp++; if (flag_z !== 1'b0)     begin n_err++; $display("FAIL rst_flag_z: got %b, required 0", flag_z); end
      n_cmp++; if (res_data !== 16'h0)  begin n_err++; $display("FAIL rst_res_data: got %h, required 0000", res_data); end
      n_cmp++; if (alu_op !== 2'd2)     begin n_err++; $display("FAIL rst_alu_op: got %0d, required 2", alu_op); end
      n_cmp++; if (err_op !== 1'b0)     begin n_err++; $display("FAIL rst_err_op: got %b, required 0", err_op); end
   endtask

   task automatic test_add_zero();
      res_ready = 1'b1;
      in_valid = 1'b1; in_op = 2'd0; in_a = 16'h0003; in_b = 16'hFFFD;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %b, required 0", res_valid); end
      tick();
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b, required 1", res_valid); end
      n_cmp++; if (res_data !== 16'h0000) begin n_err++; $display("FAIL add_data: got %h, required 0000", res_data); end
      n_cmp++; if (res_z !== 1'b1) begin n_err++; $display("FAIL add_res_z: got %b, required 1", res_z); end
      tick();
      n_cmp++; if (flag_z !== 1'b1) begin n_err++; $display("FAIL add_flag_z: got %b, required 1", flag_z); end
      drain();
   endtask

   task automatic test_order();
      res_ready = 1'b1;
      in_valid = 1'b1; in_op = 2'd1; in_a = 16'h00FF; in_b = 16'h0F0F;
      tick();
      in_op = 2'd2; in_a = 16'hAAAA; in_b = 16'h1234;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (res_data !== 16'h0FF0 || res_z !== 1'b0) begin n_err++; $display("FAIL order_first: got %h z=%b, required 0ff0 z=0", res_data, res_z); end
      tick();
      n_cmp++; if (res_data !== 16'h1234 || res_valid !== 1'b1) begin n_err++; $display("FAIL order_second: got %h v=%b, required 1234 v=1", res_data, res_valid); end
      tick();
      n_cmp++; if (flag_z !== 1'b0) begin n_err++; $display("FAIL order_flag_z: got %b, required 0", flag_z); end
      drain();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [W-1:0] held;
      res_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_op = 2'(i % 3); in_a = 16'h0100 + 16'(i); in_b = 16'h0011 * 16'(i + 1);
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++; if (acc != 5) begin n_err++; $display("FAIL bp_accepted: got %0d, required 5", acc); end
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL bp_count: got %0d, required 4", count); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_res_valid: got %b, required 1", res_valid); end
      held = res_data;
      tick();
      n_cmp++; if (res_data !== held) begin n_err++; $display("FAIL bp_stable: got %h, required %h", res_data, held); end
      res_ready = 1'b1;
      tick();
      n_cmp++; if (in_ready !== 1'b1 || count !== 3'd3) begin n_err++; $display("FAIL bp_after_pop: got rdy=%b cnt=%0d, required 1/3", in_ready, count); end
      drain();
   endtask

   task automatic test_illegal();
      res_ready = 1'b1;
      in_valid = 1'b1; in_op = 2'd3; in_a = 16'h1111; in_b = 16'h2222;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (err_op !== 1'b1) begin n_err++; $display("FAIL ill_err_op: got %b, required 1", err_op); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL ill_count: got %0d, required 0", count); end
      tick();
      n_cmp++; if (err_op !== 1'b0) begin n_err++; $display("FAIL ill_err_pulse: got %b, required 0", err_op); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL ill_res_valid: got %b, required 0", res_valid); end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_op = 2'($urandom_range(0, 2)); in_a = 16'($urandom); in_b = 16'($urandom);
         tick();
         if (i >= 1) begin
            n_cmp++;
            if (res_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b, required 1", i, res_valid); end
         end
      end
      drain();
   endtask

   task automatic test_midop_reset();
      res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_op = 2'd0; in_a = 16'h0020 + 16'(i); in_b = 16'h0001;
         tick();
      end
      in_valid = 1'b0;
      n_cmp++; if (count !== 3'd3 || res_valid !== 1'b1) begin n_err++; $display("FAIL mr_setup: got cnt=%0d v=%b, required 3/1", count, res_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL mr_count: got %0d, required 0", count); end
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL mr_res_valid: got %b, required 0", res_valid); end
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      res_ready = 1'b1;
      repeat (5) tick();
      n_cmp++; if (res_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL mr_after: got v=%b cnt=%0d, required 0/0", res_valid, count); end
   endtask

   initial begin
      test_reset();
      test_add_zero();
      test_order();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_midop_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter W, default 16, operand/result width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  queue can accept a request.
REQ-008 in_op  input  2  ALU op: 0 add, 1 xor, 2 pass B, 3 illegal.
REQ-009 in_a  input  W  operand A.
REQ-010 in_b  input  W  operand B.
REQ-011 alu_a  output  W  operand A to combinational ALU.
REQ-012 alu_b  output  W  operand B to combinational ALU.
REQ-013 alu_op  output  2  op code to combinational ALU.
REQ-014 alu_out  input  W  ALU result.
REQ-015 alu_z  input  1  ALU zero flag.
REQ-016 res_valid  output  1  result register holds a result.
REQ-017 res_ready  input  1  consumer takes result.
REQ-018 res_data  output  W  registered result.
REQ-019 res_z  output  1  registered zero flag of res_data.
REQ-020 flag_z  output  1  architectural Z flag, last consumed result's zero flag.
REQ-021 count  output  log2(DEPTH)+1  queued entries, excluding result register.
REQ-022 err_op  output  1  one-cycle pulse on illegal op.

Function
REQ-023 Queue SHALL be FIFO of {op,a,b}, DEPTH entries, read/write pointers wrapping modulo DEPTH.
REQ-024 in_ready SHALL be 1 iff count<DEPTH; no same-cycle pass-through when full.
REQ-025 Push SHALL occur on edge where in_valid&&in_ready&&in_op!=3.
REQ-026 in_valid&&in_ready&&in_op==3 SHALL not enqueue; err_op=1 for exactly the following cycle.
REQ-027 alu_a/alu_b/alu_op SHALL combinationally present FIFO head; when empty drive 0/0/2.
REQ-028 Pop SHALL occur on edge where count>0 && (!res_valid || res_ready); same edge loads res_data<=alu_out, res_z<=alu_z, res_valid<=1.
REQ-029 res_valid&&res_ready with no pop SHALL clear res_valid; res_data/res_z hold value.
REQ-030 flag_z SHALL load res_z on every edge with res_valid&&res_ready; else hold.
REQ-031 Simultaneous push and pop SHALL leave count unchanged; order SHALL be strictly FIFO.
REQ-032 Latency: push at edge N into empty queue with empty/draining result register SHALL give res_valid=1 after edge N+1.
REQ-033 Throughput SHALL be one result per cycle with res_ready held 1.
REQ-034 res_data/res_z SHALL stay stable while res_valid&&!res_ready.
REQ-035 Capacity SHALL be DEPTH queued plus 1 in result register.

Reset
REQ-036 rst_n=0 SHALL immediately clear pointers, count=0, res_valid=0, res_data=0, res_z=0, flag_z=0, err_op=0, regardless of clk.
REQ-037 Reset mid-operation SHALL discard all queued entries and pending result; nothing emitted after release.
REQ-038 in_ready SHALL be 1 from first cycle after release.

Verification
REQ-039 Reset: release rst_n -> in_ready=1, res_valid=0, count=0, flag_z=0, res_data=0x0000, alu_op=2.
REQ-040 Add zero: res_ready=1, push op0 A=0x0003 B=0xFFFD -> one edge later res_valid=1, res_data=0x0000, res_z=1; next edge flag_z=1.
REQ-041 Order: push xor 0x00FF/0x0F0F then pass-B 0x1234, res_ready=1 -> res_data 0x0FF0 (res_z=0) then 0x1234 on consecutive cycles.
REQ-042 Backpressure: res_ready=0, push 6 back-to-back -> 5 accepted, count=4, in_ready=0; res_ready=1 -> 5 results in push order, in_ready=1 after first pop.
REQ-043 Illegal op: push op3 A=0x1111 B=0x2222 -> err_op=1 one cycle, count unchanged, no res_valid.
REQ-044 Mid-op reset: 3 queued plus pending result, pulse rst_n low between edges -> count=0, res_valid=0 immediately; no results after release.
